// File: rtl/div_sequencer_pkg.sv
// Shared types and default sizing for the divider step sequencer.
// The entry struct describes one step-table record at default widths.
package div_seq_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int W_DEF     = 16;
  localparam int DUR_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} div_seq_state_t;

  typedef struct packed {
    logic [W_DEF-1:0]     div;
    logic [DUR_W_DEF-1:0] dur;
  } div_seq_entry_t;
endpackage

// File: rtl/div_sequencer_if.sv
// Step-table write port plus the pl/en/din/clk_out connection to the divider.
// master = sequencer side, slave = front end / divider side.
interface div_sequencer_if import div_seq_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF,
  parameter int DUR_W = DUR_W_DEF
) ();
  localparam int AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [W-1:0]     wr_div;
  logic [DUR_W-1:0] wr_dur;
  logic             div_tick;
  logic             div_pl;
  logic             div_en;
  logic [W-1:0]     div_din;

  modport master (
    input  wr_en, wr_addr, wr_div, wr_dur, div_tick,
    output div_pl, div_en, div_din
  );

  modport slave (
    output wr_en, wr_addr, wr_div, wr_dur, div_tick,
    input  div_pl, div_en, div_din
  );
endinterface

// File: rtl/div_sequencer_table.sv
// Step table: DEPTH entries of {divisor, duration}, synchronous write,
// asynchronous read, cleared by reset.
module div_seq_table import div_seq_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [W-1:0]     wr_div,
  input  logic [DUR_W-1:0] wr_dur,
  input  logic [AW-1:0]    rd_addr,
  output logic [W-1:0]     rd_div,
  output logic [DUR_W-1:0] rd_dur
);
  logic [W+DUR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= {wr_div, wr_dur};
    end
  end

  assign {rd_div, rd_dur} = mem[rd_addr];
endmodule

// File: rtl/div_sequencer.sv
// Walks the step table, loading each divisor into the divider and running it
// for the step's number of clk_out periods; plays once or loops, stop aborts.
module div_sequencer import div_seq_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = W_DEF,
  parameter int DUR_W = DUR_W_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  div_sequencer_if.master bus,
  input  logic [AW:0]   num_steps,
  input  logic          loop,
  input  logic          start,
  input  logic          stop,
  output logic          busy,
  output logic [AW-1:0] step_idx,
  output logic          done
);
  div_seq_state_t   state, state_nxt;
  logic [AW-1:0]    idx, idx_nxt, last_l, last_nxt;
  logic [DUR_W-1:0] cnt, cnt_nxt, dur_l;
  logic             tick_q, loop_l, rise, run_done;
  logic [W-1:0]     rd_div;
  logic [DUR_W-1:0] rd_dur;
  logic [AW:0]      ns_clamp;

  // Read at the index being entered so LOAD sees the entry's current value.
  div_seq_table #(.DEPTH(DEPTH), .W(W), .DUR_W(DUR_W)) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_div  (bus.wr_div),
    .wr_dur  (bus.wr_dur),
    .rd_addr (idx_nxt),
    .rd_div  (rd_div),
    .rd_dur  (rd_dur)
  );

  always_comb begin
    ns_clamp = num_steps;
    if (num_steps == '0)
      ns_clamp = (AW+1)'(1);
    else if (num_steps > (AW+1)'(DEPTH))
      ns_clamp = (AW+1)'(DEPTH);
    last_nxt = AW'(ns_clamp - 1'b1);
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    run_done  = 1'b0;
    rise      = bus.div_tick & ~tick_q;
    case (state)
      IDLE: if (start) begin
        state_nxt = LOAD;
        idx_nxt   = '0;
      end
      LOAD: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
      RUN: begin
        if (rise) cnt_nxt = cnt + 1'b1;
        if (cnt_nxt == dur_l) begin
          state_nxt = LOAD;
          if (idx != last_l) begin
            idx_nxt = idx + 1'b1;
          end else if (loop_l) begin
            idx_nxt = '0;
          end else begin
            state_nxt = IDLE;
            run_done  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (stop) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      run_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      tick_q      <= 1'b0;
      dur_l       <= '0;
      loop_l      <= 1'b0;
      last_l      <= '0;
      bus.div_pl  <= 1'b0;
      bus.div_en  <= 1'b0;
      bus.div_din <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      cnt    <= cnt_nxt;
      tick_q <= (state == RUN) & bus.div_tick;
      if (state == IDLE && start) begin
        loop_l <= loop;
        last_l <= last_nxt;
      end
      // Zero divisor/duration are promoted to 1 when the step is latched.
      if (state_nxt == LOAD) begin
        bus.div_din <= (rd_div == '0) ? W'(1) : rd_div;
        dur_l       <= (rd_dur == '0) ? DUR_W'(1) : rd_dur;
      end
      bus.div_pl <= (state_nxt == LOAD);
      bus.div_en <= (state_nxt == RUN);
      busy       <= (state_nxt != IDLE);
      done       <= run_done;
    end
  end

  assign step_idx = idx;
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Step sequencer that drives the team's programmable clock divider (parallel-load/enable/16-bit divisor interface) through a programmed list of divisor values. Each step loads one divisor, runs the divider for a programmed number of output periods, then moves to the next step. A run plays once or loops. The block sits between the register/control front end and the divider instance, replacing direct software pokes of `pl`/`en`/`din`.

## Interface
Parameters:
- `DEPTH`, 8: number of step-table entries (power of two).
- `W`, 16: divisor width; matches divider `din`.
- `DUR_W`, 8: per-step duration width, counted in divider output periods.

Ports:
- `clk` in 1: single clock, shared with the divider.
- `rst_n` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: write the step table this cycle.
- `wr_addr` in log2(DEPTH): table entry to write.
- `wr_div` in W: divisor for the entry.
- `wr_dur` in DUR_W: duration for the entry.
- `num_steps` in log2(DEPTH)+1: steps per run; latched on start; 0 is treated as 1, values >DEPTH as DEPTH.
- `loop` in 1: latched on start; 1 means wrap to step 0 after the last step.
- `start` in 1: begin a run; ignored while `busy`.
- `stop` in 1: abort immediately.
- `div_tick` in 1: divider `clk_out`.
- `div_pl` out 1: divider parallel load.
- `div_en` out 1: divider enable.
- `div_din` out W: divisor to the divider.
- `busy` out 1: run in progress.
- `step_idx` out log2(DEPTH): current step.
- `done` out 1: one-cycle pulse when a non-looping run completes.

## Operation
- FSM states: IDLE, LOAD, RUN.
- IDLE, on `start`: latch `num_steps` and `loop`, set idx=0, go to LOAD.
- LOAD, one cycle:
  - `div_pl`=1, `div_en`=0, `div_din`=table[idx].div.
  - A table divisor of 0 is driven as 1.
  - Clear the period counter and the `div_tick` edge register, then go to RUN.
- RUN:
  - `div_en`=1, `div_pl`=0.
  - Each rising edge of `div_tick` (previous sample 0, current 1) increments the period counter.
  - When the count reaches table[idx].dur (dur 0 is treated as 1), the step ends:
    - idx < last: idx+1, go to LOAD.
    - idx == last and loop=1: idx=0, go to LOAD.
    - idx == last and loop=0: go to IDLE and pulse `done`.
- `stop` in any state: go to IDLE next cycle, `div_en`=0, `div_pl`=0, no `done` pulse, idx reset to 0.
- `start` and `stop` in the same cycle: `stop` wins and the block stays in IDLE.
- Table writes are allowed at any time. A new value takes effect the next time that entry enters LOAD. The step currently in RUN keeps its latched divisor and duration.
- Period counter is DUR_W bits and never wraps: the step ends at equality.
- `busy` = (state != IDLE).

## Timing
- All outputs are registered.
- Reset values: `div_pl`=0, `div_en`=0, `div_din`=0, `busy`=0, `step_idx`=0, `done`=0. State is IDLE, counters are 0, and the table is all-zero.
- Cycle sequence from `start` sampled high in cycle t:
  - t+1: LOAD (`div_pl`=1, `busy`=1).
  - t+2: RUN.
- Step end, detected at cycle e:
  - e+1: LOAD of the next step.
  - Inter-step gap: exactly one cycle with `div_en`=0.
- Final step of a non-looping run: at e+1, `done`=1, `busy`=0, and `div_en`=0, all in the same cycle.
- Reset asserted mid-run: all outputs return to reset values asynchronously; the table is cleared.

## Structure
- Package `div_seq_pkg`:
  - State enum `div_seq_state_t` (IDLE, LOAD, RUN).
  - Default constants for `DEPTH`, `W`, `DUR_W`.
  - Entry struct {div, dur}.
- Sub-module `div_seq_table`: DEPTH x (W+DUR_W) register file with a synchronous write port and an asynchronous read port indexed by idx. It is reset by `rst_n`.
- Top level contains the FSM, idx, period counter, tick edge register, and latched duration/loop/last.

## Test plan
- Reset with all inputs at 0 -> every output at its reset value; `start` pulse with the table all-zero -> divisor driven as 1, duration 1, `done` after the first `div_tick` rise.
- Table {(4,2),(10,3)}, `num_steps`=2, `loop`=0, `start` -> two `div_pl` pulses with `div_din`=4 then 10, 2 then 3 `div_tick` periods respectively, then `done` for one cycle and `busy`=0.
- Same table with `loop`=1 -> `step_idx` sequence 0,1,0,1,... and no `done`; `stop` during the second step -> `div_en`=0 and `busy`=0 next cycle, no `done`.
- `start` and `stop` asserted together in IDLE -> stays IDLE; `start` during RUN -> ignored, `step_idx` unchanged.
- Write entry 0 := (7,1) while step 0 is in RUN with (4,2) -> current step still completes after 2 periods; the next loop pass loads 7.
- Assert `rst_n` low in the middle of RUN -> `div_en`/`busy` drop immediately, table reads 0 after release, and a new `start` behaves as in the first scenario.
